// File: rtl/slip_rx_decoder_pkg.sv
// Shared SLIP framing constants and decoder state encoding.
// Used by slip_rx_decoder and any block that builds or inspects SLIP streams.
package slip_rx_decoder_pkg;

   localparam logic [7:0] SLIP_END     = 8'hC0;
   localparam logic [7:0] SLIP_ESC     = 8'hDB;
   localparam logic [7:0] SLIP_ESC_END = 8'hDC;
   localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

   typedef enum logic [1:0] {
      ST_NORM    = 2'd0,
      ST_ESC     = 2'd1,
      ST_DISCARD = 2'd2
   } slip_state_t;

   // Only meaningful for ESC_END / ESC_ESC; callers qualify the input first.
   function automatic logic [7:0] slip_unescape(input logic [7:0] b);
      return (b == SLIP_ESC_END) ? SLIP_END : SLIP_ESC;
   endfunction

endpackage

// File: rtl/slip_rx_decoder.sv
// SLIP (RFC 1055) receive decoder: strips framing from a rdy/ack byte stream and
// emits payload bytes with an end-of-frame flag; malformed or oversize frames are dropped.
module slip_rx_decoder
   import slip_rx_decoder_pkg::*;
#(
   parameter int unsigned MAX_LEN = 4096,
   parameter int unsigned LEN_W   = 13
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_rdy,
   output logic       in_ack,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_last,
   input  logic       out_ack,
   output logic [7:0] err_cnt
);

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

   slip_state_t      r_state;
   slip_state_t      w_state_nxt;
   logic [7:0]       r_pend;
   logic [7:0]       w_pend_nxt;
   logic             r_pend_v;
   logic             w_pend_v_nxt;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] w_len_nxt;
   logic             r_in_ack;
   logic [7:0]       r_out_data;
   logic             r_out_valid;
   logic             r_out_last;
   logic [7:0]       r_err_cnt;

   logic             w_emit;
   logic             w_emit_last;
   logic             w_err;
   logic             w_data_v;
   logic [7:0]       w_data;
   logic             w_stall;
   logic             w_take;

   // Decode of the byte currently presented on in_data; only committed when taken.
   always_comb begin
      w_state_nxt  = r_state;
      w_pend_nxt   = r_pend;
      w_pend_v_nxt = r_pend_v;
      w_len_nxt    = r_len;
      w_emit       = 1'b0;
      w_emit_last  = 1'b0;
      w_err        = 1'b0;
      w_data_v     = 1'b0;
      w_data       = in_data;

      case (r_state)
         ST_NORM: begin
            if (in_data == SLIP_END) begin
               w_emit       = r_pend_v;
               w_emit_last  = 1'b1;
               w_pend_v_nxt = 1'b0;
               w_len_nxt    = '0;
            end else if (in_data == SLIP_ESC) begin
               w_state_nxt = ST_ESC;
            end else begin
               w_data_v = 1'b1;
            end
         end
         ST_ESC: begin
            if (in_data == SLIP_ESC_END || in_data == SLIP_ESC_ESC) begin
               w_data_v    = 1'b1;
               w_data      = slip_unescape(in_data);
               w_state_nxt = ST_NORM;
            end else if (in_data == SLIP_END) begin
               w_err       = 1'b1;
               w_state_nxt = ST_NORM;
            end else begin
               w_err       = 1'b1;
               w_state_nxt = ST_DISCARD;
            end
         end
         ST_DISCARD: begin
            if (in_data == SLIP_END) begin
               w_state_nxt = ST_NORM;
            end
         end
         default: w_state_nxt = ST_NORM;
      endcase

      // Payload byte path shared by plain and escaped data; overflow overrides the return to NORM.
      if (w_data_v) begin
         if (r_len >= LEN_MAX) begin
            w_err       = 1'b1;
            w_state_nxt = ST_DISCARD;
         end else begin
            w_emit       = r_pend_v;
            w_emit_last  = 1'b0;
            w_pend_nxt   = w_data;
            w_pend_v_nxt = 1'b1;
            w_len_nxt    = r_len + LEN_W'(1);
         end
      end

      if (w_err) begin
         w_emit       = 1'b0;
         w_pend_v_nxt = 1'b0;
         w_len_nxt    = '0;
      end
   end

   assign w_stall = w_emit && r_out_valid && !out_ack;
   assign w_take  = in_rdy && !r_in_ack && !w_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_NORM;
      end else if (w_take) begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend      <= '0;
         r_pend_v    <= 1'b0;
         r_len       <= '0;
         r_in_ack    <= 1'b0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         // Level ack: held until upstream drops rdy, so one byte per rdy assertion.
         r_in_ack <= w_take || (r_in_ack && in_rdy);

         if (w_take) begin
            r_pend   <= w_pend_nxt;
            r_pend_v <= w_pend_v_nxt;
            r_len    <= w_len_nxt;
            if (w_err && r_err_cnt != 8'hFF) begin
               r_err_cnt <= r_err_cnt + 8'd1;
            end
         end

         if (w_take && w_emit) begin
            r_out_data  <= r_pend;
            r_out_last  <= w_emit_last;
            r_out_valid <= 1'b1;
         end else if (out_ack) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign in_ack    = r_in_ack;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_slip_rx_decoder.sv
// Directed testbench for slip_rx_decoder (MAX_LEN=4) with a free-running output consumer.
module tb_slip_rx_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_rdy;
   logic       in_ack;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_last;
   logic       out_ack;
   logic [7:0] err_cnt;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned hold_bad = 0;
   logic        cons_en = 1'b0;
   logic [8:0]  got[$];
   logic [8:0]  exp_q[$];

   slip_rx_decoder #(.MAX_LEN(4), .LEN_W(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_rdy   (in_rdy),
      .in_ack   (in_ack),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_last (out_last),
      .out_ack  (out_ack),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Consumer: acks every valid byte it sees, recording {last, data}.
   initial begin
      out_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (cons_en && out_valid === 1'b1) begin
            got.push_back({out_last, out_data});
            out_ack = 1'b1;
         end else begin
            out_ack = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b, input int unsigned hold);
      int unsigned t;
      in_data = b;
      in_rdy  = 1'b1;
      t = 0;
      do begin
         tick(1);
         t++;
      end while (in_ack !== 1'b1 && t < 200);
      chk($sformatf("ack_rise_%02h", b), {31'd0, in_ack}, 32'd1);
      repeat (hold) begin
         tick(1);
         if (in_ack !== 1'b1) hold_bad++;
      end
      in_rdy = 1'b0;
      tick(1);
      if (in_ack !== 1'b0) hold_bad++;
   endtask

   task automatic expect_byte(input logic [7:0] d, input logic last);
      exp_q.push_back({last, d});
   endtask

   task automatic check_out(input string tag);
      logic [8:0] obs;
      tick(6);
      chk({tag, "_count"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         obs = (i < got.size()) ? got[i] : 9'bx;
         chk($sformatf("%s_byte%0d", tag, i), {23'd0, obs}, {23'd0, exp_q[i]});
      end
      got.delete();
      exp_q.delete();
   endtask

   initial begin
      int unsigned bad;
      int unsigned t;
      rst     = 1'b1;
      in_data = 8'h00;
      in_rdy  = 1'b0;
      tick(3);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_last",  {31'd0, out_last},  32'd0);
      chk("rst_out_data",  {24'd0, out_data},  32'd0);
      chk("rst_in_ack",    {31'd0, in_ack},    32'd0);
      chk("rst_err_cnt",   {24'd0, err_cnt},   32'd0);
      rst = 1'b0;
      cons_en = 1'b1;
      tick(2);

      // Basic frame
      send(8'hC0, 0); send(8'h01, 0); send(8'h02, 0); send(8'hC0, 0);
      expect_byte(8'h01, 1'b0); expect_byte(8'h02, 1'b1);
      check_out("t1");
      chk("t1_err", {24'd0, err_cnt}, 32'd0);

      // Escapes
      send(8'hC0, 0); send(8'hDB, 0); send(8'hDC, 0); send(8'hDB, 0);
      send(8'hDD, 0); send(8'h7E, 0); send(8'hC0, 0);
      expect_byte(8'hC0, 1'b0); expect_byte(8'hDB, 1'b0); expect_byte(8'h7E, 1'b1);
      check_out("t2");

      // Empty frames
      send(8'hC0, 0); send(8'hC0, 0); send(8'hC0, 0); send(8'hAA, 0); send(8'hC0, 0);
      expect_byte(8'hAA, 1'b1);
      check_out("t3");

      // Bad escape -> discard until END
      send(8'h11, 0); send(8'hDB, 0); send(8'h55, 0); send(8'h22, 0); send(8'hC0, 0);
      send(8'h33, 0); send(8'hC0, 0);
      expect_byte(8'h33, 1'b1);
      check_out("t4");
      chk("t4_err", {24'd0, err_cnt}, 32'd1);

      // Backpressure: consumer withheld while upstream holds rdy
      cons_en  = 1'b0;
      hold_bad = 0;
      send(8'hAA, 20); send(8'hBB, 20);
      in_data = 8'hCC;
      in_rdy  = 1'b1;
      bad = 0;
      repeat (50) begin
         tick(1);
         if (in_ack !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hAA) bad++;
      end
      chk("stall_hold", bad, 32'd0);
      cons_en = 1'b1;
      t = 0;
      do begin
         tick(1);
         t++;
      end while (in_ack !== 1'b1 && t < 20);
      chk("stall_release_ack", {31'd0, in_ack}, 32'd1);
      repeat (20) begin
         tick(1);
         if (in_ack !== 1'b1) hold_bad++;
      end
      in_rdy = 1'b0;
      tick(1);
      if (in_ack !== 1'b0) hold_bad++;
      send(8'hC0, 20);
      chk("ack_level_hold", hold_bad, 32'd0);
      expect_byte(8'hAA, 1'b0); expect_byte(8'hBB, 1'b0); expect_byte(8'hCC, 1'b1);
      check_out("t5");
      chk("t5_err", {24'd0, err_cnt}, 32'd1);

      // Exactly MAX_LEN bytes is accepted
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); send(8'hC0, 0);
      expect_byte(8'h01, 1'b0); expect_byte(8'h02, 1'b0);
      expect_byte(8'h03, 1'b0); expect_byte(8'h04, 1'b1);
      check_out("t6");
      chk("t6_err", {24'd0, err_cnt}, 32'd1);

      // Overflow: 6 data bytes, only the first 3 ever leave, never with last
      for (int i = 1; i <= 6; i++) send(8'(i), 0);
      send(8'hC0, 0);
      send(8'h09, 0); send(8'hC0, 0);
      expect_byte(8'h01, 1'b0); expect_byte(8'h02, 1'b0); expect_byte(8'h03, 1'b0);
      expect_byte(8'h09, 1'b1);
      check_out("t7");
      chk("t7_err", {24'd0, err_cnt}, 32'd2);

      // ESC immediately followed by END drops the frame in place
      send(8'h77, 0); send(8'hDB, 0); send(8'hC0, 0); send(8'h88, 0); send(8'hC0, 0);
      expect_byte(8'h88, 1'b1);
      check_out("t8");
      chk("t8_err", {24'd0, err_cnt}, 32'd3);

      // Asynchronous reset mid-frame with ack high and a byte pending output
      cons_en = 1'b0;
      send(8'h11, 0);
      in_data = 8'h22;
      in_rdy  = 1'b1;
      t = 0;
      do begin
         tick(1);
         t++;
      end while (in_ack !== 1'b1 && t < 20);
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_in_ack",    {31'd0, in_ack},    32'd0);
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_out_data",  {24'd0, out_data},  32'd0);
      chk("arst_err_cnt",   {24'd0, err_cnt},   32'd0);
      in_rdy = 1'b0;
      tick(2);
      rst = 1'b0;
      cons_en = 1'b1;
      tick(1);
      send(8'h5A, 0); send(8'hC0, 0);
      expect_byte(8'h5A, 1'b1);
      check_out("t9");
      chk("t9_err", {24'd0, err_cnt}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
